// File: rtl/cic_integ_chain.sv
// cic_integ_chain: cascade of STAGES signed integrators forming the front half
// of the CIC decimator. Each stage sign-extends into an AW+1 bit sum and either
// wraps modulo 2^AW or clamps to the signed AW-bit range. Any stage overflow
// sets a sticky flag. dout is either the registered last stage or its next value.
module cic_integ_chain #(
  parameter int W      = 10,
  parameter int AW     = 16,
  parameter int STAGES = 3,
  parameter int SAT    = 0,
  parameter int OUTREG = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 din_vld,
  input  logic signed [W-1:0]  din,
  input  logic                 ovf_clr,
  output logic signed [AW-1:0] dout,
  output logic                 dout_vld,
  output logic                 ovf
);

  localparam logic signed [AW-1:0] MAX_V = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V = {1'b1, {(AW-1){1'b0}}};

  logic signed [AW-1:0] acc     [STAGES];
  logic signed [AW-1:0] addend  [STAGES];
  logic signed [AW:0]   sum     [STAGES];
  logic signed [AW-1:0] acc_nxt [STAGES];
  logic [STAGES-1:0]    stage_ovf;
  logic                 upd;
  logic                 ovf_any;

  assign upd     = din_vld & ~clr;
  assign ovf_any = upd & (|stage_ovf);

  // Select each stage's input: the sample for stage 0, the old previous stage otherwise.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      addend[k] = '0;
    end
    addend[0] = AW'(din);
    for (int unsigned k = 1; k < STAGES; k++) begin
      addend[k] = acc[k-1];
    end
  end

  // Form each stage sum one bit wide, detect overflow, then wrap or clamp.
  always_comb begin
    stage_ovf = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      sum[k]       = (AW+1)'(acc[k]) + (AW+1)'(addend[k]);
      stage_ovf[k] = sum[k][AW] ^ sum[k][AW-1];
      if (stage_ovf[k] && (SAT != 0)) begin
        acc_nxt[k] = sum[k][AW] ? MIN_V : MAX_V;
      end else begin
        acc_nxt[k] = sum[k][AW-1:0];
      end
    end
  end

  // Accumulator state: clear wins over a valid sample, otherwise hold when idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        acc[k] <= '0;
      end
    end else if (clr) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        acc[k] <= '0;
      end
    end else if (din_vld) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        acc[k] <= acc_nxt[k];
      end
    end
  end

  // Sticky overflow flag; a new overflow beats a simultaneous clear request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf <= 1'b0;
    end else if (ovf_any) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  generate
    if (OUTREG != 0) begin : g_reg_out
      logic vld_q;

      // Registered output qualifier, one cycle after the accepted sample.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          vld_q <= 1'b0;
        end else begin
          vld_q <= upd;
        end
      end

      assign dout     = acc[STAGES-1];
      assign dout_vld = vld_q;
    end else begin : g_comb_out
      // Look-ahead output; forced to zero while reset is asserted so reset
      // takes effect immediately even with din_vld high.
      assign dout     = !rstn ? '0 :
                        clr   ? '0 :
                        din_vld ? acc_nxt[STAGES-1] : acc[STAGES-1];
      assign dout_vld = rstn & upd;
    end
  endgenerate

endmodule

// File: tb/tb_cic_integ_chain.sv
// Bench for cic_integ_chain: four configurations share one stimulus stream.
// A plain-arithmetic reference model feeds per-instance scoreboards that a
// separate monitor drains; directed phases also check the documented sequences.
module tb_cic_integ_chain;

  localparam int NI = 4;
  // instance 0: W10 AW16 S3 wrap reg; 1: W8 AW8 S1 sat reg;
  // instance 2: W8 AW8 S1 wrap reg;   3: W10 AW16 S1 wrap comb
  localparam int CFG_W   [NI] = '{10, 8, 8, 10};
  localparam int CFG_AW  [NI] = '{16, 8, 8, 16};
  localparam int CFG_ST  [NI] = '{3, 1, 1, 1};
  localparam int CFG_SAT [NI] = '{0, 1, 0, 0};
  localparam int CFG_OR  [NI] = '{1, 1, 1, 0};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clr = 1'b0;
  logic din_vld = 1'b0;
  logic ovf_clr = 1'b0;
  logic signed [9:0] din10 = '0;
  logic signed [7:0] din8 = '0;

  logic signed [15:0] dout_a, dout_c;
  logic signed [7:0]  dout_s, dout_w;
  logic vld_a, vld_s, vld_w, vld_c;
  logic ovf_a, ovf_s, ovf_w, ovf_c;

  always #5 clk = ~clk;

  cic_integ_chain #(.W(10), .AW(16), .STAGES(3), .SAT(0), .OUTREG(1)) u_a (
    .clk(clk), .rstn(rstn), .clr(clr), .din_vld(din_vld), .din(din10),
    .ovf_clr(ovf_clr), .dout(dout_a), .dout_vld(vld_a), .ovf(ovf_a));

  cic_integ_chain #(.W(8), .AW(8), .STAGES(1), .SAT(1), .OUTREG(1)) u_s (
    .clk(clk), .rstn(rstn), .clr(clr), .din_vld(din_vld), .din(din8),
    .ovf_clr(ovf_clr), .dout(dout_s), .dout_vld(vld_s), .ovf(ovf_s));

  cic_integ_chain #(.W(8), .AW(8), .STAGES(1), .SAT(0), .OUTREG(1)) u_w (
    .clk(clk), .rstn(rstn), .clr(clr), .din_vld(din_vld), .din(din8),
    .ovf_clr(ovf_clr), .dout(dout_w), .dout_vld(vld_w), .ovf(ovf_w));

  cic_integ_chain #(.W(10), .AW(16), .STAGES(1), .SAT(0), .OUTREG(0)) u_c (
    .clk(clk), .rstn(rstn), .clr(clr), .din_vld(din_vld), .din(din10),
    .ovf_clr(ovf_clr), .dout(dout_c), .dout_vld(vld_c), .ovf(ovf_c));

  typedef struct {
    bit     vld;
    longint d;
    bit     ovf;
  } exp_t;

  exp_t   sb   [NI][$];
  longint logq [NI][$];
  longint expq [$];
  longint m_acc [NI][8];
  bit     m_ovf [NI];
  int     n_cmp = 0;
  int     n_err = 0;
  bit     mon_en = 1'b0;

  function automatic void chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic longint act_dout(int i);
    case (i)
      0: return longint'(dout_a);
      1: return longint'(dout_s);
      2: return longint'(dout_w);
      default: return longint'(dout_c);
    endcase
  endfunction

  function automatic longint act_vld(int i);
    case (i)
      0: return longint'(vld_a);
      1: return longint'(vld_s);
      2: return longint'(vld_w);
      default: return longint'(vld_c);
    endcase
  endfunction

  function automatic longint act_ovf(int i);
    case (i)
      0: return longint'(ovf_a);
      1: return longint'(ovf_s);
      2: return longint'(ovf_w);
      default: return longint'(ovf_c);
    endcase
  endfunction

  // Reference: integer sums checked against the signed range, then clamped or
  // folded back modulo 2^AW.
  function automatic void model_step(int i, longint x, bit v, bit c, bit oc);
    longint span, lo, hi, s, inp;
    longint old [8];
    bit any;
    span = longint'(1) << CFG_AW[i];
    lo   = -(span / 2);
    hi   = span / 2 - 1;
    any  = 1'b0;
    old  = m_acc[i];
    if (c) begin
      for (int k = 0; k < 8; k++) m_acc[i][k] = 0;
    end else if (v) begin
      for (int k = 0; k < CFG_ST[i]; k++) begin
        if (k == 0) inp = x;
        else        inp = old[k-1];
        s = old[k] + inp;
        if (s > hi || s < lo) begin
          any = 1'b1;
          if (CFG_SAT[i] != 0) s = (s > hi) ? hi : lo;
          else                 s = (((s - lo) % span) + span) % span + lo;
        end
        m_acc[i][k] = s;
      end
    end
    if (any)     m_ovf[i] = 1'b1;
    else if (oc) m_ovf[i] = 1'b0;
  endfunction

  task automatic cyc(bit v, longint a, longint b, bit c = 1'b0, bit oc = 1'b0);
    exp_t e;
    bit pre;
    @(negedge clk);
    din_vld = v;
    clr     = c;
    ovf_clr = oc;
    din10   = a[9:0];
    din8    = b[7:0];
    for (int i = 0; i < NI; i++) begin
      pre = m_ovf[i];
      model_step(i, (CFG_W[i] == 8) ? b : a, v, c, oc);
      e.vld = v && !c;
      e.d   = m_acc[i][CFG_ST[i]-1];
      e.ovf = (CFG_OR[i] != 0) ? m_ovf[i] : pre;
      sb[i].push_back(e);
    end
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0, 0, 0);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < NI; i++) logq[i].delete();
  endtask

  task automatic chk_log(int i, string nm);
    chk($sformatf("%s_len", nm), logq[i].size(), expq.size());
    for (int j = 0; j < expq.size() && j < logq[i].size(); j++)
      chk($sformatf("%s[%0d]", nm, j), logq[i][j], expq[j]);
  endtask

  task automatic chk_zero(string nm);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_dout%0d", nm, i), act_dout(i), 0);
      chk($sformatf("%s_vld%0d", nm, i), act_vld(i), 0);
      chk($sformatf("%s_ovf%0d", nm, i), act_ovf(i), 0);
    end
  endtask

  task automatic flush_model();
    for (int i = 0; i < NI; i++) begin
      sb[i].delete();
      for (int k = 0; k < 8; k++) m_acc[i][k] = 0;
      m_ovf[i] = 1'b0;
    end
  endtask

  // Monitor: pops one expected entry per presented output cycle and compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        for (int i = 0; i < NI; i++) begin
          if (sb[i].size() > CFG_OR[i]) begin
            e = sb[i].pop_front();
            chk($sformatf("sb_vld%0d", i), act_vld(i), longint'(e.vld));
            chk($sformatf("sb_dout%0d", i), act_dout(i), e.d);
            chk($sformatf("sb_ovf%0d", i), act_ovf(i), longint'(e.ovf));
            if (e.vld && act_vld(i) == 1) logq[i].push_back(act_dout(i));
          end
        end
      end
    end
  end

  initial begin
    flush_model();
    #3;
    chk_zero("reset");
    @(negedge clk);
    rstn   = 1'b1;
    mon_en = 1'b1;

    // Impulse on the 3-stage chain; saturate and wrap runs on the 8-bit ones.
    clear_logs();
    for (int j = 0; j < 6; j++)
      cyc(1'b1, (j == 0) ? 1 : 0, (j < 3) ? 100 : -128);
    idle(2);
    expq = {0, 0, 1, 3, 6, 10};           chk_log(0, "impulse");
    expq = {100, 127, 127, -1, -128, -128}; chk_log(1, "sat");
    expq = {100, -56, 44, -84, 44, -84};  chk_log(2, "wrap");
    expq = {1, 1, 1, 1, 1, 1};            chk_log(3, "comb_acc");
    chk("ovf_sat_set", act_ovf(1), 1);
    chk("ovf_wrap_set", act_ovf(2), 1);
    chk("ovf_imp_clear", act_ovf(0), 0);

    // Sticky flag clear, then clear requested during an overflowing sample.
    cyc(1'b0, 0, 0, 1'b0, 1'b1);
    idle(1);
    chk("ovf_clr_wrap", act_ovf(2), 0);
    chk("ovf_clr_sat", act_ovf(1), 0);
    cyc(1'b1, 0, -128, 1'b0, 1'b1);
    idle(1);
    chk("ovf_set_wins_wrap", act_ovf(2), 1);
    chk("ovf_set_wins_sat", act_ovf(1), 1);

    // Impulse again with valid gaps after a clear.
    cyc(1'b0, 0, 0, 1'b1);
    idle(1);
    clear_logs();
    for (int j = 0; j < 6; j++) begin
      cyc(1'b1, (j == 0) ? 1 : 0, 0);
      if (j < 5) idle(2);
    end
    idle(2);
    expq = {0, 0, 1, 3, 6, 10};
    chk_log(0, "gap_impulse");

    // Clear together with a valid sample drops it and keeps ovf.
    cyc(1'b1, 7, 20);
    cyc(1'b1, -3, 20);
    cyc(1'b1, 5, 5, 1'b1);
    idle(1);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("clr_dout%0d", i), act_dout(i), 0);
      chk($sformatf("clr_vld%0d", i), act_vld(i), 0);
    end
    chk("clr_keeps_ovf_sat", act_ovf(1), 1);
    chk("clr_keeps_ovf_wrap", act_ovf(2), 1);
    clear_logs();
    cyc(1'b1, 5, 5);
    idle(2);
    expq = {5};
    chk_log(1, "post_clr_sat");
    chk_log(2, "post_clr_wrap");
    chk_log(3, "post_clr_comb");

    // Randomised traffic.
    for (int j = 0; j < 400; j++) begin
      cyc(($urandom_range(0, 3) != 0),
          longint'($urandom_range(0, 1023)) - 512,
          longint'($urandom_range(0, 255)) - 128,
          ($urandom_range(0, 31) == 0),
          ($urandom_range(0, 9) == 0));
    end

    // Asynchronous reset in the middle of valid traffic.
    for (int j = 0; j < 4; j++) cyc(1'b1, 300, 90);
    @(negedge clk);
    #5;
    mon_en = 1'b0;
    rstn   = 1'b0;
    #1;
    chk_zero("async_rst");
    din_vld = 1'b0;
    clr     = 1'b0;
    ovf_clr = 1'b0;
    flush_model();
    @(negedge clk);
    rstn   = 1'b1;
    mon_en = 1'b1;
    cyc(1'b1, 3, 3);
    #1;
    chk("comb_first_dout", act_dout(3), 3);
    chk("comb_first_vld", act_vld(3), 1);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
